// File: rtl/bicantor_pkg.sv
// Shared definitions for the 2-wide decode/issue path: RV32I major opcodes,
// the canonical NOP and the issue-stage state encoding.
package bicantor_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_HOLD_B = 1'b1
   } state_t;

endpackage

// File: rtl/dual_issue_stage_if.sv
// Fetch-to-issue instruction-pair channel.
// A pair transfers on a clock edge where pair_valid_i and pair_ready_o are both
// high; fetch must hold the pair stable while valid is high and ready is low.
interface dual_issue_stage_if #(
   parameter int XLEN = 32
);
   logic            pair_valid_i;
   logic            pair_ready_o;
   logic [31:0]     A_instr_i;
   logic [31:0]     B_instr_i;
   logic [XLEN-1:0] A_pc_i;
   logic [XLEN-1:0] B_pc_i;

   modport master (
      output pair_valid_i, A_instr_i, B_instr_i, A_pc_i, B_pc_i,
      input  pair_ready_o
   );

   modport slave (
      input  pair_valid_i, A_instr_i, B_instr_i, A_pc_i, B_pc_i,
      output pair_ready_o
   );
endinterface

// File: rtl/instr_field_decode.sv
// Combinational RV32I field decode for one issue slot: register fields plus
// the operand-use and instruction-class flags used for pair hazard checks.
module instr_field_decode
   import bicantor_pkg::*;
(
   input  logic [31:0] instr,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd,
   output logic        uses_rs1,
   output logic        uses_rs2,
   output logic        writes_rd,
   output logic        is_mem,
   output logic        is_ctrl
);
   logic [6:0] opc;
   logic       unused_fields;

   assign opc           = instr[6:0];
   assign unused_fields = ^{instr[31:25], instr[14:12]};

   always_comb begin
      uses_rs1  = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
      uses_rs2  = (opc == OPC_BRANCH || opc == OPC_STORE || opc == OPC_OP);
      writes_rd = (opc == OPC_LUI  || opc == OPC_AUIPC || opc == OPC_JAL ||
                   opc == OPC_JALR || opc == OPC_LOAD  || opc == OPC_OPIMM ||
                   opc == OPC_OP);
      is_mem    = (opc == OPC_LOAD || opc == OPC_STORE);
      is_ctrl   = (opc == OPC_BRANCH || opc == OPC_JAL || opc == OPC_JALR);
   end

   // Unused source fields read as x0 so the register file sees a quiet address.
   assign rs1 = uses_rs1 ? instr[19:15] : 5'd0;
   assign rs2 = uses_rs2 ? instr[24:20] : 5'd0;
   assign rd  = instr[11:7];

endmodule

// File: rtl/dual_issue_stage.sv
// Two-wide decode/issue stage in front of the dual-port register file; splits
// hazardous pairs over two cycles. Optional counters under ISSUE_STATS_EN.
module dual_issue_stage
   import bicantor_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   dual_issue_stage_if.slave fetch,
   input  logic              stall_i,
   input  logic              flush_i,
   output logic [4:0]        A_rs1_addr_o,
   output logic [4:0]        A_rs2_addr_o,
   output logic [4:0]        B_rs1_addr_o,
   output logic [4:0]        B_rs2_addr_o,
   output logic              A_valid_o,
   output logic              B_valid_o,
   output logic [31:0]       A_instr_o,
   output logic [31:0]       B_instr_o,
   output logic [XLEN-1:0]   A_pc_o,
   output logic [XLEN-1:0]   B_pc_o,
   output logic [4:0]        A_rd_addr_o,
   output logic [4:0]        B_rd_addr_o,
   output logic              A_rd_write_o,
   output logic              B_rd_write_o,
   output state_t            state_o
`ifdef ISSUE_STATS_EN
   ,
   output logic [31:0]       dual_count_o,
   output logic [31:0]       split_count_o,
   output logic [31:0]       stall_count_o
`endif
);
   state_t          state;
   logic [31:0]     hold_instr;
   logic [XLEN-1:0] hold_pc;
   logic [31:0]     a_src_instr;
   logic            holding;

   logic [4:0] a_rs1, a_rs2, a_rd, b_rs1, b_rs2, b_rd;
   logic       a_writes, b_writes, a_is_mem, b_is_mem, a_is_ctrl;
   logic       b_uses_rs1, b_uses_rs2;
   logic       unused_a_uses_rs1, unused_a_uses_rs2, unused_b_is_ctrl;
   logic       a_wr, b_wr, raw_hazard, split, ready, accept;

   assign holding = (state == ST_HOLD_B);

   // While a split B waits, slot A's decoder (and the A read ports) serve it.
   assign a_src_instr = holding ? hold_instr : fetch.A_instr_i;

   instr_field_decode u_dec_a (
      .instr     (a_src_instr),
      .rs1       (a_rs1),
      .rs2       (a_rs2),
      .rd        (a_rd),
      .uses_rs1  (unused_a_uses_rs1),
      .uses_rs2  (unused_a_uses_rs2),
      .writes_rd (a_writes),
      .is_mem    (a_is_mem),
      .is_ctrl   (a_is_ctrl)
   );

   instr_field_decode u_dec_b (
      .instr     (fetch.B_instr_i),
      .rs1       (b_rs1),
      .rs2       (b_rs2),
      .rd        (b_rd),
      .uses_rs1  (b_uses_rs1),
      .uses_rs2  (b_uses_rs2),
      .writes_rd (b_writes),
      .is_mem    (b_is_mem),
      .is_ctrl   (unused_b_is_ctrl)
   );

   assign a_wr = a_writes && (a_rd != 5'd0);
   assign b_wr = b_writes && (b_rd != 5'd0);

   assign raw_hazard = a_wr && ((b_uses_rs1 && (b_rs1 == a_rd)) ||
                                (b_uses_rs2 && (b_rs2 == a_rd)));
   assign split      = raw_hazard || (a_is_mem && b_is_mem) || a_is_ctrl;

   assign ready              = !holding && !stall_i && !flush_i;
   assign accept             = fetch.pair_valid_i && ready;
   assign fetch.pair_ready_o = ready;

   assign A_rs1_addr_o = a_rs1;
   assign A_rs2_addr_o = a_rs2;
   assign B_rs1_addr_o = holding ? 5'd0 : b_rs1;
   assign B_rs2_addr_o = holding ? 5'd0 : b_rs2;
   assign state_o      = state;

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state        <= ST_NORMAL;
         hold_instr   <= '0;
         hold_pc      <= '0;
         A_valid_o    <= 1'b0;
         B_valid_o    <= 1'b0;
         A_instr_o    <= NOP;
         B_instr_o    <= NOP;
         A_pc_o       <= RESET_PC;
         B_pc_o       <= RESET_PC;
         A_rd_addr_o  <= 5'd0;
         B_rd_addr_o  <= 5'd0;
         A_rd_write_o <= 1'b0;
         B_rd_write_o <= 1'b0;
      end else if (flush_i) begin
         state      <= ST_NORMAL;
         hold_instr <= '0;
         hold_pc    <= '0;
         A_valid_o  <= 1'b0;
         B_valid_o  <= 1'b0;
      end else if (!stall_i) begin
         case (state)
            ST_NORMAL: begin
               if (fetch.pair_valid_i) begin
                  A_valid_o    <= 1'b1;
                  A_instr_o    <= fetch.A_instr_i;
                  A_pc_o       <= fetch.A_pc_i;
                  A_rd_addr_o  <= a_rd;
                  A_rd_write_o <= a_wr;
                  if (split) begin
                     B_valid_o  <= 1'b0;
                     hold_instr <= fetch.B_instr_i;
                     hold_pc    <= fetch.B_pc_i;
                     state      <= ST_HOLD_B;
                  end else begin
                     B_valid_o    <= 1'b1;
                     B_instr_o    <= fetch.B_instr_i;
                     B_pc_o       <= fetch.B_pc_i;
                     B_rd_addr_o  <= b_rd;
                     B_rd_write_o <= b_wr;
                  end
               end else begin
                  A_valid_o <= 1'b0;
                  B_valid_o <= 1'b0;
               end
            end
            ST_HOLD_B: begin
               // Decoder A is already looking at the held instruction.
               A_valid_o    <= 1'b1;
               A_instr_o    <= hold_instr;
               A_pc_o       <= hold_pc;
               A_rd_addr_o  <= a_rd;
               A_rd_write_o <= a_wr;
               B_valid_o    <= 1'b0;
               state        <= ST_NORMAL;
            end
            default: state <= ST_NORMAL;
         endcase
      end
   end

`ifdef ISSUE_STATS_EN
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         dual_count_o  <= '0;
         split_count_o <= '0;
         stall_count_o <= '0;
      end else if (!flush_i) begin
         if (accept && !split) dual_count_o  <= dual_count_o + 32'd1;
         if (accept && split)  split_count_o <= split_count_o + 32'd1;
         if (stall_i)          stall_count_o <= stall_count_o + 32'd1;
      end
   end
`endif

endmodule
